countdown_timer: RTL and testbench

Countdown counterpart to the elapsed-time counter. Loads a 16-bit seconds value, decrements it once per prescaled second, and flags expiry when it reaches zero. Used by the drive controller for timeouts such as bubble heater warm-up and access watchdog. Supports pause/resume and abort, and runs on the system master clock.

---
 rtl/countdown_timer.sv | 128 ++++++++++++
 tb/tb_countdown_timer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loads a seconds value, decrements it once per prescaled
// second and flags expiry at zero. Supports pause/resume and abort.
// Per-edge priority: abort, then start, then pause, then the prescaler tick.
module countdown_timer #(
   parameter int TICK_DIV = 48000000,
   parameter int PRESC_W  = $clog2(TICK_DIV)
) (
   input  logic        MCLK,
   input  logic        nRESET,
   input  logic [15:0] TIMESET,
   input  logic        nSTART,
   input  logic        nPAUSE,
   input  logic        nABORT,
   output logic [15:0] TIMELEFT,
   output logic        RUNNING,
   output logic        PAUSED,
   output logic        EXPIRED,
   output logic        EXPIRE_PULSE
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

   state_t             state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [15:0]        timeleft_q, timeleft_d;
   logic               running_q, running_d;
   logic               paused_q, paused_d;
   logic               expired_q, expired_d;
   logic               pulse_q, pulse_d;
   logic               load;
   logic               do_tick;

   // Next-state, prescaler and seconds counter; status flags decoded from the next state
   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      timeleft_d = timeleft_q;
      load       = 1'b0;
      do_tick    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Abort in IDLE is a no-op, but it still masks a simultaneous start.
            if (nABORT && !nSTART) load = 1'b1;
         end
         ST_RUN: begin
            // A start request while running is ignored; it does not stall the tick.
            if (!nABORT)      state_d = ST_IDLE;
            else if (!nPAUSE) state_d = ST_PAUSE;
            else              do_tick = 1'b1;
         end
         ST_PAUSE: begin
            // Releasing pause counts on the same edge, so the frozen time equals
            // exactly the number of edges nPAUSE was sampled low.
            if (!nABORT) state_d = ST_IDLE;
            else if (nPAUSE) begin
               state_d = ST_RUN;
               do_tick = 1'b1;
            end
         end
         ST_DONE: begin
            if (!nABORT)      state_d = ST_IDLE;
            else if (!nSTART) load = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         timeleft_d = TIMESET;
         presc_d    = '0;
         state_d    = (TIMESET != 16'd0) ? ST_RUN : ST_DONE;
      end

      if (do_tick) begin
         if (presc_q < PRESC_MAX) begin
            presc_d = presc_q + 1'b1;
         end else begin
            presc_d = '0;
            // Never wrap below zero; reaching zero ends the countdown on this edge.
            if (timeleft_q != 16'd0) begin
               timeleft_d = timeleft_q - 16'd1;
               if (timeleft_q == 16'd1) state_d = ST_DONE;
            end
         end
      end

      running_d = (state_d == ST_RUN);
      paused_d  = (state_d == ST_PAUSE);
      expired_d = (state_d == ST_DONE);
      // A reload straight back into DONE counts as a fresh expiry.
      pulse_d   = (state_d == ST_DONE) && ((state_q != ST_DONE) || load);
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge MCLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         timeleft_q <= 16'd0;
         running_q  <= 1'b0;
         paused_q   <= 1'b0;
         expired_q  <= 1'b0;
         pulse_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         timeleft_q <= timeleft_d;
         running_q  <= running_d;
         paused_q   <= paused_d;
         expired_q  <= expired_d;
         pulse_q    <= pulse_d;
      end
   end

   assign TIMELEFT     = timeleft_q;
   assign RUNNING      = running_q;
   assign PAUSED       = paused_q;
   assign EXPIRED      = expired_q;
   assign EXPIRE_PULSE = pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer (TICK_DIV=4): directed stimulus pushes expected
// snapshots tagged with an edge number; a monitor pops and compares them.
module tb_countdown_timer;

   logic        MCLK;
   logic        nRESET;
   logic [15:0] TIMESET;
   logic        nSTART;
   logic        nPAUSE;
   logic        nABORT;
   logic [15:0] TIMELEFT;
   logic        RUNNING;
   logic        PAUSED;
   logic        EXPIRED;
   logic        EXPIRE_PULSE;

   countdown_timer #(.TICK_DIV(4)) dut (
      .MCLK(MCLK), .nRESET(nRESET), .TIMESET(TIMESET), .nSTART(nSTART),
      .nPAUSE(nPAUSE), .nABORT(nABORT), .TIMELEFT(TIMELEFT), .RUNNING(RUNNING),
      .PAUSED(PAUSED), .EXPIRED(EXPIRED), .EXPIRE_PULSE(EXPIRE_PULSE)
   );

   typedef struct {
      int          cyc;     // edge number after which to sample; -1 = async probe
      string       name;
      logic [15:0] tl;
      logic        run;
      logic        pau;
      logic        ex;
      logic        pls;
      logic        chk_ex;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic probe = 1'b0;

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   always @(posedge MCLK) cyc <= cyc + 1;

   task automatic push(input int c, input string nm, input logic [15:0] tl,
                       input logic run, input logic pau, input logic ex,
                       input logic pls, input logic chk_ex);
      exp_t e;
      e.cyc = c; e.name = nm; e.tl = tl; e.run = run; e.pau = pau;
      e.ex = ex; e.pls = pls; e.chk_ex = chk_ex;
      sb.push_back(e);
   endtask

   task automatic run_until(input int t);
      while (cyc < t) @(negedge MCLK);
   endtask

   // Monitor: compares the DUT against queued expectations
   initial begin
      exp_t e;
      logic ok;
      logic matched_pls;
      forever begin
         @(negedge MCLK or posedge probe);
         matched_pls = 1'b0;
         while (sb.size() > 0 &&
                ((probe && sb[0].cyc < 0) || (!probe && sb[0].cyc == cyc))) begin
            e = sb.pop_front();
            n_checks++;
            ok = (TIMELEFT == e.tl) && (RUNNING == e.run) && (PAUSED == e.pau) &&
                 (EXPIRE_PULSE == e.pls) && (!e.chk_ex || EXPIRED == e.ex);
            if (e.pls) matched_pls = 1'b1;
            if (!ok) begin
               n_fail++;
               $display("FAIL %s edge=%0d got tl=%0d run=%b pau=%b exp=%b pls=%b want tl=%0d run=%b pau=%b exp=%b(chk=%b) pls=%b",
                        e.name, cyc, TIMELEFT, RUNNING, PAUSED, EXPIRED, EXPIRE_PULSE,
                        e.tl, e.run, e.pau, e.ex, e.chk_ex, e.pls);
            end
         end
         if (!probe) begin
            if (sb.size() > 0 && sb[0].cyc >= 0 && sb[0].cyc < cyc) begin
               e = sb.pop_front();
               n_checks++;
               n_fail++;
               $display("FAIL %s not sampled: edge now %0d required %0d", e.name, cyc, e.cyc);
            end
            if (EXPIRE_PULSE && !matched_pls) begin
               n_checks++;
               n_fail++;
               $display("FAIL stray_pulse edge=%0d got EXPIRE_PULSE=1 required 0", cyc);
            end
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      int e0;
      nRESET = 1'b0; TIMESET = 16'd0; nSTART = 1'b1; nPAUSE = 1'b1; nABORT = 1'b1;

      // Reset state, then idle after release
      push(2, "rst_state", 16'd0, 0, 0, 0, 0, 1);
      push(4, "idle_after_rst", 16'd0, 0, 0, 0, 0, 1);
      repeat (3) @(negedge MCLK);
      nRESET = 1'b1;
      run_until(5);

      // TIMESET=3: 3,2,1,0 at E0, +4, +8, +12
      e0 = cyc + 1; TIMESET = 16'd3; nSTART = 1'b0;
      push(e0,      "t1_load",     16'd3, 1, 0, 0, 0, 1);
      push(e0 + 3,  "t1_pre_dec",  16'd3, 1, 0, 0, 0, 1);
      push(e0 + 4,  "t1_dec1",     16'd2, 1, 0, 0, 0, 1);
      push(e0 + 8,  "t1_dec2",     16'd1, 1, 0, 0, 0, 1);
      push(e0 + 11, "t1_last_run", 16'd1, 1, 0, 0, 0, 1);
      push(e0 + 12, "t1_expire",   16'd0, 0, 0, 1, 1, 1);
      push(e0 + 13, "t1_pls_off",  16'd0, 0, 0, 1, 0, 1);
      @(negedge MCLK); nSTART = 1'b1;
      run_until(e0 + 14);

      // In DONE, restart with TIMESET=0: pulse again, EXPIRED stays high
      e0 = cyc + 1; TIMESET = 16'd0; nSTART = 1'b0;
      push(e0,     "t2_reload0", 16'd0, 0, 0, 1, 1, 1);
      push(e0 + 1, "t2_hold",    16'd0, 0, 0, 1, 0, 1);
      @(negedge MCLK); nSTART = 1'b1;
      run_until(e0 + 2);
      e0 = cyc + 1; nABORT = 1'b0;
      push(e0, "t2_abort", 16'd0, 0, 0, 0, 0, 1);
      @(negedge MCLK); nABORT = 1'b1;
      run_until(e0 + 2);

      // TIMESET=0 from IDLE: immediate expiry, RUNNING never set
      e0 = cyc + 1; TIMESET = 16'd0; nSTART = 1'b0;
      push(e0,     "t3_zero",    16'd0, 0, 0, 1, 1, 1);
      push(e0 + 1, "t3_pls_off", 16'd0, 0, 0, 1, 0, 1);
      push(e0 + 2, "t3_done",    16'd0, 0, 0, 1, 0, 1);
      @(negedge MCLK); nSTART = 1'b1;
      run_until(e0 + 3);

      // In DONE, restart with TIMESET=1: expiry and second pulse 4 edges later
      e0 = cyc + 1; TIMESET = 16'd1; nSTART = 1'b0;
      push(e0,     "t5_load",    16'd1, 1, 0, 0, 0, 0);
      push(e0 + 3, "t5_pre",     16'd1, 1, 0, 0, 0, 0);
      push(e0 + 4, "t5_expire",  16'd0, 0, 0, 1, 1, 1);
      push(e0 + 5, "t5_pls_off", 16'd0, 0, 0, 1, 0, 1);
      @(negedge MCLK); nSTART = 1'b1;
      run_until(e0 + 6);
      e0 = cyc + 1; nABORT = 1'b0;
      push(e0, "t5_abort", 16'd0, 0, 0, 0, 0, 1);
      @(negedge MCLK); nABORT = 1'b1;
      run_until(e0 + 2);

      // TIMESET=2 with nPAUSE low for 10 edges from E0+2: expiry at E0+18
      e0 = cyc + 1; TIMESET = 16'd2; nSTART = 1'b0;
      push(e0 + 1,  "t4_pre_pause", 16'd2, 1, 0, 0, 0, 1);
      push(e0 + 2,  "t4_paused",    16'd2, 0, 1, 0, 0, 1);
      push(e0 + 11, "t4_pause_end", 16'd2, 0, 1, 0, 0, 1);
      push(e0 + 12, "t4_resume",    16'd2, 1, 0, 0, 0, 1);
      push(e0 + 14, "t4_dec1",      16'd1, 1, 0, 0, 0, 1);
      push(e0 + 17, "t4_last_run",  16'd1, 1, 0, 0, 0, 1);
      push(e0 + 18, "t4_expire",    16'd0, 0, 0, 1, 1, 1);
      push(e0 + 19, "t4_pls_off",   16'd0, 0, 0, 1, 0, 1);
      @(negedge MCLK); nSTART = 1'b1;
      @(negedge MCLK); nPAUSE = 1'b0;
      run_until(e0 + 11); nPAUSE = 1'b1;
      run_until(e0 + 20);
      e0 = cyc + 1; nABORT = 1'b0;
      push(e0, "t4_abort", 16'd0, 0, 0, 0, 0, 1);
      @(negedge MCLK); nABORT = 1'b1;
      run_until(e0 + 2);

      // TIMESET=5, start ignored while running, abort at E0+9 keeps TIMELEFT=3
      e0 = cyc + 1; TIMESET = 16'd5; nSTART = 1'b0;
      push(e0,      "t6_load",        16'd5, 1, 0, 0, 0, 1);
      push(e0 + 4,  "t6_dec1",        16'd4, 1, 0, 0, 0, 1);
      push(e0 + 5,  "t6_no_retrig",   16'd4, 1, 0, 0, 0, 1);
      push(e0 + 8,  "t6_dec2",        16'd3, 1, 0, 0, 0, 1);
      push(e0 + 9,  "t6_abort",       16'd3, 0, 0, 0, 0, 1);
      push(e0 + 11, "t6_idle_abort",  16'd3, 0, 0, 0, 0, 1);
      push(e0 + 13, "t6_hold",        16'd3, 0, 0, 0, 0, 1);
      while (cyc < e0 + 14) begin
         @(negedge MCLK);
         case (cyc - e0)
            0:  nSTART = 1'b1;
            4:  begin nSTART = 1'b0; TIMESET = 16'd9; end
            5:  nSTART = 1'b1;
            8:  nABORT = 1'b0;
            9:  nABORT = 1'b1;
            10: nABORT = 1'b0;
            11: nABORT = 1'b1;
            default: ;
         endcase
      end

      // TIMESET=65535, 100 edges, then asynchronous reset between edges
      e0 = cyc + 1; TIMESET = 16'hFFFF; nSTART = 1'b0;
      push(e0,       "t7_load",      16'd65535, 1, 0, 0, 0, 1);
      push(e0 + 100, "t7_run",       16'd65510, 1, 0, 0, 0, 1);
      push(-1,       "t7_async_rst", 16'd0,     0, 0, 0, 0, 1);
      push(e0 + 101, "t7_rst_held",  16'd0,     0, 0, 0, 0, 1);
      push(e0 + 103, "t7_idle",      16'd0,     0, 0, 0, 0, 1);
      @(negedge MCLK); nSTART = 1'b1;
      run_until(e0 + 100);
      #2 nRESET = 1'b0;
      #1 probe = 1'b1;
      #1 probe = 1'b0;
      run_until(e0 + 101);
      nRESET = 1'b1;
      run_until(e0 + 104);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
